// File: rtl/data_mem_mmio.sv
// data_mem_mmio: word-addressed data RAM plus an MMIO page holding a cycle counter, timer, and GPIO.
// Optional TIMER_PRESCALE_EN adds an 8-bit timer prescaler (PSC at offset 0x1C).
module data_mem_mmio #(
  parameter int          RAM_ADR_BITS = 10,
  parameter logic [15:0] MMIO_PAGE    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_adr,
  input  logic [31:0] data_out,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_in,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic        irq
);
  logic [31:0] ram [2**RAM_ADR_BITS];
  logic [RAM_ADR_BITS-1:0] ram_idx;
  logic [2:0]  off;
  logic        mmio_sel, wr;
  logic        wr_tcnt, wr_tload, wr_ctrl, wr_stat, wr_gpio, wr_psc;
  logic [31:0] cycle_q, tcnt_q, tcnt_d, tload_q, tload_d, gpio_q, gpio_d;
  logic [31:0] sync1_q, sync2_q, mmio_rd;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        flag_q, flag_d, en_d, step, hw_set;
  logic [7:0]  psc_q, psc_d, pcnt_q, pcnt_d;
  logic        unused;

  assign unused   = &{1'b0, data_adr};
  assign mmio_sel = data_adr[31:16] == MMIO_PAGE;
  assign ram_idx  = data_adr[RAM_ADR_BITS+1:2];
  assign off      = data_adr[4:2];
  assign wr       = mem_write & mmio_sel;
  assign wr_tcnt  = wr && off == 3'd1;
  assign wr_tload = wr && off == 3'd2;
  assign wr_ctrl  = wr && off == 3'd3;
  assign wr_stat  = wr && off == 3'd4;
  assign wr_gpio  = wr && off == 3'd5;
  assign wr_psc   = wr && off == 3'd7;

  always_ff @(posedge clk)
    if (mem_write && !mmio_sel) ram[ram_idx] <= data_out;

  always_comb begin
    mmio_rd = '0;
    case (off)
      3'd0: mmio_rd = cycle_q;
      3'd1: mmio_rd = tcnt_q;
      3'd2: mmio_rd = tload_q;
      3'd3: mmio_rd = {29'd0, ctrl_q};
      3'd4: mmio_rd = {31'd0, flag_q};
      3'd5: mmio_rd = gpio_q;
      3'd6: mmio_rd = sync2_q;
      3'd7: mmio_rd = {24'd0, psc_q};
      default: mmio_rd = '0;
    endcase
  end

  assign data_in  = !mem_read ? '0 : mmio_sel ? mmio_rd : ram[ram_idx];
  assign gpio_out = gpio_q;
  assign irq      = flag_q & ctrl_q[2];

`ifdef TIMER_PRESCALE_EN
  assign step   = ctrl_q[0] && pcnt_q == psc_q;
  assign psc_d  = wr_psc ? data_out[7:0] : psc_q;
  assign pcnt_d = (wr_psc || wr_ctrl) ? 8'd0 : !ctrl_q[0] ? pcnt_q : (pcnt_q == psc_q) ? 8'd0 : pcnt_q + 8'd1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      psc_q  <= '0;
      pcnt_q <= '0;
    end else begin
      psc_q  <= psc_d;
      pcnt_q <= pcnt_d;
    end
`else
  assign step   = ctrl_q[0];
  assign psc_q  = '0;
  assign psc_d  = '0;
  assign pcnt_q = '0;
  assign pcnt_d = '0;
`endif

  // software writes to TCNT/CTRL take priority over the timer step; a hardware FLAG set beats W1C
  always_comb begin
    tcnt_d = tcnt_q;
    en_d   = ctrl_q[0];
    hw_set = 1'b0;
    if (step) begin
      if (tcnt_q == '0) begin
        hw_set = 1'b1;
        tcnt_d = ctrl_q[1] ? tload_q : '0;
        en_d   = ctrl_q[1];
      end else begin
        tcnt_d = tcnt_q - 32'd1;
      end
    end
    if (wr_tcnt) tcnt_d = data_out;
    ctrl_d  = wr_ctrl ? data_out[2:0] : {ctrl_q[2:1], en_d};
    flag_d  = hw_set | (flag_q & ~(wr_stat & data_out[0]));
    tload_d = wr_tload ? data_out : tload_q;
    gpio_d  = wr_gpio ? data_out : gpio_q;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cycle_q <= '0;
      tcnt_q  <= '0;
      tload_q <= '0;
      ctrl_q  <= '0;
      flag_q  <= 1'b0;
      gpio_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      tcnt_q  <= tcnt_d;
      tload_q <= tload_d;
      ctrl_q  <= ctrl_d;
      flag_q  <= flag_d;
      gpio_q  <= gpio_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: table-driven register checks, hand sequences for timer corners, randomized RAM vs. model.
module tb_data_mem_mmio;
  localparam logic [31:0] MB = 32'hFFFF_0000;
`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] PSC_EXP = 32'hFF;
`else
  localparam logic [31:0] PSC_EXP = 32'h0;
`endif
  logic clk = 0, rst = 0, mem_read = 0, mem_write = 0, irq;
  logic [31:0] data_adr = 0, data_out = 0, data_in, gpio_in = 0, gpio_out;
  int ncmp = 0, nerr = 0;

  typedef struct {logic [31:0] adr; logic [31:0] wd; logic [31:0] exp;} vec_t;
  vec_t tbl[7];
  logic [31:0] mdl [int];

  data_mem_mmio dut (.clk(clk), .rst(rst), .data_adr(data_adr), .data_out(data_out),
    .mem_read(mem_read), .mem_write(mem_write), .data_in(data_in),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    data_adr = a; data_out = d; mem_write = 1;
    tick(1);
    mem_write = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    data_adr = a; mem_read = 1;
    #1 d = data_in;
    mem_read = 0;
  endtask

  task automatic chk_rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(nm, d, exp);
  endtask

  initial begin
    logic [31:0] c0, c1, a, d;
    int n;
    tbl[0] = '{MB + 8,    32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[1] = '{MB + 4,    32'h1234_5678, 32'h1234_5678};
    tbl[2] = '{MB + 'hC,  32'hFFFF_FFF6, 32'h6};
    tbl[3] = '{MB + 'h10, 32'h0,         32'h0};
    tbl[4] = '{MB + 'h14, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
    tbl[5] = '{MB + 'h1C, 32'h1FF,       PSC_EXP};
    tbl[6] = '{MB + 'hC,  32'h0,         32'h0};

    tick(3);
    chk_rd("reset_cycle", MB, 0);
    chk_rd("reset_tcnt", MB + 4, 0);
    chk("reset_gpio_out", gpio_out, 0);
    chk("reset_irq", {31'd0, irq}, 0);
    rst = 1;
    tick(1);

    wr(32'h10, 32'hDEAD_BEEF);
    chk_rd("ram_load", 32'h10, 32'hDEAD_BEEF);
    chk_rd("ram_alias", 32'h1010, 32'hDEAD_BEEF);
    data_adr = 32'h10; mem_read = 0;
    #1 chk("no_read_zero", data_in, 0);

    wr(32'h20, 32'h1111_1111);
    data_adr = 32'h20; data_out = 32'h2222_2222; mem_read = 1; mem_write = 1;
    #1 chk("rw_old", data_in, 32'h1111_1111);
    tick(1);
    mem_write = 0; mem_read = 0;
    chk_rd("rw_new", 32'h20, 32'h2222_2222);

    foreach (tbl[i]) begin
      wr(tbl[i].adr, tbl[i].wd);
      chk_rd($sformatf("tbl%0d", i), tbl[i].adr, tbl[i].exp);
    end
    chk("tbl_gpio_pin", gpio_out, 32'h5A5A_5A5A);

    rd(MB, c0);
    tick(7);
    rd(MB, c1);
    chk("cycle_diff7", c1 - c0, 7);
    rd(MB, c0);
    wr(MB, 32'h0);
    rd(MB, c1);
    chk("cycle_wr_ignored", c1 - c0, 1);

    wr(MB + 8, 3); wr(MB + 4, 3); wr(MB + 'hC, 7);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk_rd($sformatf("auto_flag_t%0d", k), MB + 'h10, k == 4);
    end
    chk("auto_irq", {31'd0, irq}, 1);
    wr(MB + 'h10, 1);
    chk("w1c_irq_drop", {31'd0, irq}, 0);
    tick(2);
    chk_rd("auto_flag_t7", MB + 'h10, 0);
    tick(1);
    chk_rd("auto_flag_t8", MB + 'h10, 1);
    wr(MB + 'hC, 0); wr(MB + 'h10, 1);

    wr(MB + 4, 2); wr(MB + 'hC, 5);
    tick(2);
    chk_rd("once_flag_pre", MB + 'h10, 0);
    wr(MB + 'h10, 1);
    chk_rd("once_flag_beats_w1c", MB + 'h10, 1);
    chk_rd("once_en_clear", MB + 'hC, 4);
    chk("once_irq", {31'd0, irq}, 1);
    tick(3);
    chk_rd("once_tcnt_hold", MB + 4, 0);
    wr(MB + 'hC, 0); wr(MB + 'h10, 1);

    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(0, 10);
      wr(MB + 4, n); wr(MB + 'hC, 1);
      for (int k = 1; k <= n + 2; k++) begin
        tick(1);
        chk_rd($sformatf("rnd_tmr%0d_n%0d_k%0d", t, n, k), MB + 'h10, k >= n + 1);
      end
      wr(MB + 'h10, 1);
    end

    wr(MB + 'h14, 32'hA5);
    chk("gpio_out_a5", gpio_out, 32'hA5);
    chk_rd("gpio_out_rd", MB + 'h14, 32'hA5);
    gpio_in = 32'h1234;
    tick(1);
    chk_rd("gpio_in_1cyc", MB + 'h18, 0);
    tick(1);
    chk_rd("gpio_in_2cyc", MB + 'h18, 32'h1234);

    for (int i = 0; i < 40; i++) begin
      a = {16'($urandom_range(0, 16'hFFFE)), 16'($urandom)};
      d = $urandom;
      wr(a, d);
      mdl[int'(a[11:2])] = d;
    end
    foreach (mdl[k]) begin
      a = {16'($urandom_range(0, 16'hFFFE)), 4'($urandom), 10'(k), 2'($urandom)};
      chk_rd($sformatf("ram_rnd_%0d", k), a, mdl[k]);
    end

`ifdef TIMER_PRESCALE_EN
    wr(MB + 'h1C, 1); wr(MB + 8, 1); wr(MB + 4, 1); wr(MB + 'hC, 3);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk_rd($sformatf("psc_flag_t%0d", k), MB + 'h10, k == 4);
    end
    wr(MB + 'hC, 0); wr(MB + 'h10, 1);
`endif

    wr(MB + 4, 50); wr(MB + 'h14, 1); wr(MB + 'hC, 5);
    tick(5);
    rst = 0;
    #1;
    chk_rd("rst_tcnt", MB + 4, 0);
    chk_rd("rst_ctrl", MB + 'hC, 0);
    chk_rd("rst_cycle", MB, 0);
    chk_rd("rst_gpio_in", MB + 'h18, 0);
    chk("rst_gpio_out", gpio_out, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    tick(2);
    rst = 1;
    tick(1);
    chk_rd("post_rst_tcnt", MB + 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
- Data-side memory block directly downstream of the single-cycle MIPS core's data port.
- Consumes the core's data_adr, data_out, mem_read and mem_write, and returns data_in.
- Contains a word-addressed data RAM and a memory-mapped peripheral window: free-running cycle counter, down-counting timer with interrupt, and a GPIO register pair.
- Reads are combinational so the core completes a load in one cycle; all writes are synchronous.

Parameters:
- RAM_ADR_BITS, 10, log2 of RAM depth in 32-bit words (1024 words).
- MMIO_PAGE, 16'hFFFF, value of data_adr[31:16] that selects the peripheral window.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_adr  input  32  byte address from core; bits [1:0] ignored.
- data_out  input  32  store data from core.
- mem_read  input  1  load strobe.
- mem_write  input  1  store strobe.
- data_in  output  32  load data to core.
- gpio_in  input  32  external inputs, asynchronous to clk.
- gpio_out  output  32  GPIO output register.
- irq  output  1  timer interrupt request.

Behaviour:
- Decode:
  - mmio_sel = (data_adr[31:16] == MMIO_PAGE).
  - Otherwise RAM word index = data_adr[RAM_ADR_BITS+1:2]; upper bits alias.
- Read path: data_in is combinational.
  - mem_read=0 gives 0.
  - RAM hit gives the RAM word.
  - MMIO hit gives the register selected by data_adr[4:2].
  - Unmapped MMIO offsets read 0.
- Write path: on posedge clk when mem_write=1. RAM is written when mmio_sel=0; otherwise the addressed MMIO register is written.
- mem_read and mem_write both high: the read returns the old value, and the write lands at the edge.
- RAM is not reset; its contents are undefined until written.
- MMIO map (offset: register):
  - 0x00 CYCLE: read-only; +1 every cycle; wraps 32'hFFFFFFFF->0.
  - 0x04 TCNT: read/write timer count.
  - 0x08 TLOAD: read/write reload value.
  - 0x0C CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable); other bits read 0.
  - 0x10 STATUS: bit0 FLAG; write-1-to-clear; writing 0 has no effect.
  - 0x14 GPIO_OUT: read/write; drives gpio_out.
  - 0x18 GPIO_IN: read-only; gpio_in through a 2-flop synchronizer (2-cycle latency).
- Timer, each cycle with EN=1:
  - If TCNT==0: FLAG<=1. If AUTO=1, TCNT<=TLOAD. If AUTO=0, TCNT stays 0 and EN<=0.
  - Else TCNT<=TCNT-1.
  - Period is TLOAD+1 cycles.
- Simultaneous events:
  - A software write to TCNT or CTRL overrides the timer update in the same cycle.
  - A hardware FLAG set beats a W1C clear in the same cycle.
  - A CYCLE write is ignored.
- irq = FLAG & IE, combinational from registers.
- Reset values (rst=0, asynchronous): CYCLE, TCNT, TLOAD, CTRL, FLAG, GPIO_OUT and sync flops all 0; irq=0; gpio_out=0.
  - data_in follows decode, so it is 0 when mem_read=0.
  - Reset asserted mid-count aborts the timer immediately.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - Adds PSC at offset 0x1C: 8-bit, read/write, upper bits read 0.
  - Adds an 8-bit prescale counter, reset 0.
  - The timer step above only occurs on cycles where the prescale counter == PSC, at which point the prescale counter clears; otherwise it increments while EN=1.
  - Period is (TLOAD+1)*(PSC+1).
  - A write to PSC or CTRL clears the prescale counter.
- Undefined: offset 0x1C reads 0, writes are ignored, and the timer steps every cycle.

Test Plan:
- Reset then release; store 32'hDEADBEEF at 0x0000_0010, then load 0x0000_0010 -> data_in=32'hDEADBEEF on the same cycle as the load; load 0x0000_1010 (alias at RAM_ADR_BITS=10) -> 32'hDEADBEEF.
- Read CYCLE at two points 7 cycles apart -> difference exactly 7; write CYCLE -> ignored, counting continues.
- TLOAD=3, TCNT=3, CTRL=3'b111 -> FLAG and irq rise after 4 cycles, then every 4 cycles; W1C STATUS -> irq drops next cycle.
- CTRL=3'b101 (AUTO=0), TCNT=2 -> FLAG set after 3 cycles, EN reads 0, TCNT stays 0; a W1C in the same cycle as the FLAG set -> FLAG remains 1.
- Write GPIO_OUT=32'h0000_00A5 -> gpio_out=32'hA5 after the edge; drive gpio_in=32'h1234 -> GPIO_IN reads 32'h1234 from the second cycle on.
- Assert rst mid-count with TCNT=50 and GPIO_OUT=1 -> all registers, gpio_out and irq read 0 immediately. With TIMER_PRESCALE_EN, PSC=1 and TLOAD=1 -> FLAG period of 4 cycles.
